// File: rtl/puf_voter_pkg.sv
// Shared types and default sizing for the PUF response majority voter.
// Used by puf_response_voter and vote_counter.
package puf_voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_RESP_W    = 8;
  localparam int DEF_NUM_EVALS = 15;
  localparam int DEF_KEY_WORDS = 4;

  // Width needed to count 0..num_evals inclusive.
  function automatic int cnt_width(input int num_evals);
    return $clog2(num_evals + 1);
  endfunction

  // Word index width; a single-word key still gets a 1-bit index.
  function automatic int idx_width(input int key_words);
    return (key_words > 1) ? $clog2(key_words) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_NUM_EVALS);
  localparam int DEF_IDX_W = idx_width(DEF_KEY_WORDS);

endpackage

// File: rtl/puf_response_voter_vote_counter.sv
// vote_counter: per-bit ones counter for temporal majority voting.
// Optional macro STABILITY_FLAG_EN adds the unanimity flag output.
module vote_counter
  import puf_voter_pkg::*;
#(
  parameter int NUM_EVALS = DEF_NUM_EVALS,
  parameter int CNT_W     = cnt_width(NUM_EVALS)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             majority
`ifdef STABILITY_FLAG_EN
  ,
  output logic             unanimous
`endif
);

  // Count evaluations that returned 1; clear wins over increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Strict majority over an odd number of evaluations.
  assign majority = (count > CNT_W'(NUM_EVALS / 2));

`ifdef STABILITY_FLAG_EN
  // All evaluations agreed: the bit never flipped.
  assign unanimous = (count == '0) || (count == CNT_W'(NUM_EVALS));
`endif

endmodule

// File: rtl/puf_response_voter.sv
// puf_response_voter: majority-votes NUM_EVALS DAPUF evaluations per word,
// packs KEY_WORDS voted words into a key, offers it on valid/ready.
// Optional macro STABILITY_FLAG_EN adds unstable_mask (bits that flipped).
//
// Handshake: key_valid rises in DONE and holds with key_out frozen until the
// cycle where key_valid && key_ready; the FSM is back in IDLE on the next cycle.
module puf_response_voter
  import puf_voter_pkg::*;
#(
  parameter  int RESP_W    = DEF_RESP_W,
  parameter  int NUM_EVALS = DEF_NUM_EVALS,
  parameter  int KEY_WORDS = DEF_KEY_WORDS,
  localparam int KEY_W     = RESP_W * KEY_WORDS,
  localparam int CNT_W     = cnt_width(NUM_EVALS),
  localparam int IDX_W     = idx_width(KEY_WORDS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              key_ready,
  output logic              busy,
  output logic [IDX_W-1:0]  word_idx,
  output logic              key_valid,
  output state_t            dbg_state,
  output logic [KEY_W-1:0]  key_out
`ifdef STABILITY_FLAG_EN
  ,
  output logic [KEY_W-1:0]  unstable_mask
`endif
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  eval_cnt;
  logic              sample;
  logic              clear_cnt;
  logic              last_eval;
  logic              last_word;
  logic [RESP_W-1:0] voted;
  logic [CNT_W-1:0]  ones [RESP_W];
  logic              unused_ones;
`ifdef STABILITY_FLAG_EN
  logic [RESP_W-1:0] stable;
`endif

  // A sample counts only while collecting and while the word still has room.
  assign sample    = (state == COLLECT) && resp_valid && (eval_cnt < CNT_W'(NUM_EVALS));
  assign last_eval = (eval_cnt == CNT_W'(NUM_EVALS - 1));
  assign last_word = (word_idx == IDX_W'(KEY_WORDS - 1));
  assign clear_cnt = ((state == IDLE) && start) || (state == DECIDE);
  assign dbg_state = state;

  genvar b;
  generate
    for (b = 0; b < RESP_W; b++) begin : g_bit
      vote_counter #(
        .NUM_EVALS (NUM_EVALS),
        .CNT_W     (CNT_W)
      ) u_cnt (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (clear_cnt),
        .inc       (sample & resp_in[b]),
        .count     (ones[b]),
        .majority  (voted[b])
`ifdef STABILITY_FLAG_EN
        ,
        .unanimous (stable[b])
`endif
      );
    end
  endgenerate

  // Per-bit counts are only observed through the majority/unanimity flags.
  always_comb begin
    unused_ones = 1'b0;
    for (int i = 0; i < RESP_W; i++) unused_ones = unused_ones ^ (^ones[i]);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    key_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (sample && last_eval) state_nxt = DECIDE;
      end
      DECIDE: begin
        busy      = 1'b1;
        state_nxt = last_word ? DONE : COLLECT;
      end
      DONE: begin
        key_valid = 1'b1;
        if (key_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Evaluation counter for the current word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)         eval_cnt <= '0;
    else if (clear_cnt) eval_cnt <= '0;
    else if (sample)    eval_cnt <= eval_cnt + 1'b1;
  end

  // Word index: restarts at a new key, advances after each non-final decision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                                word_idx <= '0;
    else if ((state == IDLE) && start)         word_idx <= '0;
    else if ((state == DECIDE) && !last_word)  word_idx <= word_idx + 1'b1;
  end

  // Key register: voted word lands in its slot during DECIDE, otherwise held.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 key_out <= '0;
    else if (state == DECIDE)   key_out[word_idx*RESP_W +: RESP_W] <= voted;
  end

`ifdef STABILITY_FLAG_EN
  // Mark bits whose evaluations disagreed at least once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 unstable_mask <= '0;
    else if (state == DECIDE)   unstable_mask[word_idx*RESP_W +: RESP_W] <= ~stable;
  end
`endif

endmodule
